// File: rtl/bit_serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and default width.
package bit_serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_subtractor_fs_1bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module fs_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a-b LSB-first, one bit per clock, through a single
// full-subtractor cell. Result and final borrow are registered on the last bit's edge.
//
// state | meaning
// IDLE  | waiting for start; diff/borrow hold the last result
// SHIFT | one bit pair processed per edge, WIDTH edges total
// DONE  | one-cycle result-valid pulse; start here begins the next op directly
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit;
  logic             bout_bit;

  fs_1bit u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        bin_d = bout_bit;
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the completed word straight from the shifter input.
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bout_bit;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench: directed scenarios on an 8-bit instance, random regression on 8 and 16 bits.
module tb_bit_serial_subtractor;
  import bit_serial_subtractor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, borrow8, busy16, done16, borrow16;
  logic [7:0]  diff8;
  logic [15:0] diff16;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_done1, t_done2;

  // Last result the model expects each instance to be holding.
  logic [15:0] prev_diff8 = '0, prev_diff16 = '0;
  logic        prev_b8 = 1'b0, prev_b16 = 1'b0;

  bit_serial_subtractor #(.WIDTH(DEFAULT_WIDTH)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  bit_serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit wide, input logic s, input logic [15:0] av, input logic [15:0] bv);
    if (wide) begin
      start16 = s; a16 = av; b16 = bv;
    end else begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with timing checks; leaves the DUT back in IDLE.
  task automatic do_op(input bit wide, input logic [15:0] av, input logic [15:0] bv, input string tag);
    int          w;
    logic [16:0] e;
    logic [15:0] exp_diff, prev_d;
    logic        exp_b;
    w = wide ? 16 : 8;
    if (wide) begin
      e = {1'b0, av} - {1'b0, bv};
      exp_diff = e[15:0];
      exp_b    = e[16];
      prev_d   = prev_diff16;
    end else begin
      e = {9'b0, av[7:0]} - {9'b0, bv[7:0]};
      exp_diff = {8'b0, e[7:0]};
      exp_b    = e[8];
      prev_d   = prev_diff8;
    end
    set_in(wide, 1'b1, av, bv);
    tick();
    for (int i = 0; i < w; i++) begin
      set_in(wide, 1'b0, 16'($urandom), 16'($urandom));
      check({tag, "_busy"}, wide ? busy16 : busy8, 1'b1);
      check({tag, "_nodone"}, wide ? done16 : done8, 1'b0);
      check({tag, "_hold"}, wide ? diff16 : {8'b0, diff8}, prev_d);
      tick();
    end
    check({tag, "_done"}, wide ? done16 : done8, 1'b1);
    check({tag, "_busy_end"}, wide ? busy16 : busy8, 1'b0);
    check({tag, "_diff"}, wide ? diff16 : {8'b0, diff8}, exp_diff);
    check({tag, "_borrow"}, wide ? borrow16 : borrow8, exp_b);
    if (wide) begin
      prev_diff16 = exp_diff; prev_b16 = exp_b;
    end else begin
      prev_diff8 = exp_diff; prev_b8 = exp_b;
    end
    tick();
    check({tag, "_pulse1"}, wide ? done16 : done8, 1'b0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_diff", diff8, 8'h00);
    check("rst_borrow", borrow8, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b0;

    // First start after reset accepted on the first edge, then the directed vectors
    do_op(1'b0, 16'd100, 16'd37, "d100_37");
    do_op(1'b0, 16'd37, 16'd100, "d37_100");
    do_op(1'b0, 16'd0, 16'd1, "d0_1");
    do_op(1'b0, 16'hFF, 16'hFF, "dff_ff");

    // Back-to-back with start held high
    set_in(1'b0, 1'b1, 16'd10, 16'd3);
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("b2b_done1", done8, 1'b1);
    check("b2b_diff1", diff8, 8'd7);
    check("b2b_borrow1", borrow8, 1'b0);
    t_done1 = cyc;
    set_in(1'b0, 1'b1, 16'd3, 16'd10);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("b2b_busy2", busy8, 1'b1);
      check("b2b_hold2", diff8, 8'd7);
      tick();
    end
    check("b2b_done2", done8, 1'b1);
    check("b2b_diff2", diff8, 8'hF9);
    check("b2b_borrow2", borrow8, 1'b1);
    t_done2 = cyc;
    check("b2b_spacing", 64'(t_done2 - t_done1), 64'd9);
    set_in(1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    check("b2b_idle", done8, 1'b0);
    prev_diff8 = 16'hF9; prev_b8 = 1'b1;

    // start and operands disturbed on SHIFT cycle 3
    set_in(1'b0, 1'b1, 16'd200, 16'd100);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) set_in(1'b0, 1'b1, 16'd1, 16'd2);
      else        set_in(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      check("ign_busy", busy8, 1'b1);
      tick();
    end
    check("ign_done", done8, 1'b1);
    check("ign_diff", diff8, 8'd100);
    check("ign_borrow", borrow8, 1'b0);
    set_in(1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    prev_diff8 = 16'd100; prev_b8 = 1'b0;

    // Leave a result with borrow set, then abort the next op with an async reset
    do_op(1'b0, 16'd5, 16'd9, "pre_abort");
    set_in(1'b0, 1'b1, 16'd50, 16'd20);
    tick();
    set_in(1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) tick();
    check("abort_busy_pre", busy8, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_diff", diff8, 8'h00);
    check("abort_borrow", borrow8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_nopulse", done8, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_diff8 = '0; prev_b8 = 1'b0;
    prev_diff16 = '0; prev_b16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_abort_idle", done8, 1'b0);
    end
    do_op(1'b0, 16'd200, 16'd55, "d200_55");

    // Random regression on both widths
    for (int i = 0; i < 1000; i++) do_op(1'b0, 16'($urandom), 16'($urandom), "rnd8");
    for (int i = 0; i < 1000; i++) do_op(1'b1, 16'($urandom), 16'($urandom), "rnd16");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request; sampled on rising clk edge, accepted only in IDLE or DONE.
REQ-005 Port: a  input  WIDTH  minuend (unsigned); captured on the accepting edge only.
REQ-006 Port: b  input  WIDTH  subtrahend (unsigned); captured on the accepting edge only.
REQ-007 Port: busy  output  1  high while in SHIFT.
REQ-008 Port: done  output  1  one-cycle pulse; result valid.
REQ-009 Port: diff  output  WIDTH  registered result a-b modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  registered final borrow-out; 1 iff a < b (unsigned).

Function
REQ-011 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: start=1 -> load a, b into shift registers, clear borrow flop and bit counter, go SHIFT; else stay.
REQ-013 SHIFT: each edge processes one bit pair LSB-first through a 1-bit full subtractor (d = ai^bi^bin; bout = (~ai&bi) | (~(ai^bi)&bin)), shifts d into a result shift register, updates borrow flop, increments counter.
REQ-014 SHIFT: on the edge processing bit WIDTH-1, go DONE and copy result shift register to diff and final bout to borrow on that same edge.
REQ-015 Latency: start accepted on edge E0 -> done=1 during the cycle following edge E(WIDTH); exactly WIDTH edges in SHIFT.
REQ-016 DONE lasts one cycle: start=1 -> behave as REQ-012 (back-to-back op, no IDLE cycle); else go IDLE.
REQ-017 start while in SHIFT SHALL be ignored; a, b changes during SHIFT SHALL not affect the result.
REQ-018 diff and borrow SHALL hold the previous result through IDLE and SHIFT, changing only on the REQ-014 edge.
REQ-019 busy = (state==SHIFT); done = (state==DONE); both decoded from registered state, glitch-free.
REQ-020 Counter width = clog2(WIDTH); no wrap past WIDTH-1 is reachable.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, busy=0, done=0, diff=0, borrow=0, counter=0, borrow flop=0.
REQ-022 rst asserted mid-SHIFT SHALL abort the operation; no done pulse and no diff/borrow update for the aborted operation.
REQ-023 First start after rst release SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-024 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH SHALL live in a shared constants package/header, reused by bench.
REQ-025 The 1-bit full-subtractor cell SHALL be a separate combinational sub-module, fs_1bit (ports a, b, bin, d, bout), instantiated once.
REQ-026 All other logic (FSM, counter, shift registers, output registers) SHALL be in bit_serial_subtractor.

Verification
REQ-027 WIDTH=8, a=100, b=37, start 1 cycle -> busy 8 cycles, done pulse 1 cycle, diff=63 (0x3F), borrow=0.
REQ-028 a=37, b=100 -> diff=0xC1, borrow=1; a=0, b=1 -> diff=0xFF, borrow=1; a=0xFF, b=0xFF -> diff=0x00, borrow=0.
REQ-029 start held high continuously with a=10,b=3 then a=3,b=10 presented at DONE -> two back-to-back results 7/b0 then 0xF9/b1, done pulses 9 cycles apart, no IDLE cycle between.
REQ-030 start pulsed again and a,b changed on SHIFT cycle 3 -> ignored; original result delivered with nominal latency.
REQ-031 rst asserted asynchronously (between edges) on SHIFT cycle 4 -> outputs cleared immediately, no done pulse; next op 200-55 -> diff=145, borrow=0.
REQ-032 Random regression, WIDTH=8 and WIDTH=16, 1000 ops each -> diff and borrow match reference model {borrow,diff} = {1'b0,a} - {1'b0,b}.
